// File: rtl/ysyx_exec_ctrl_if.sv
// Handshake bundle between the execution sequencer and the instruction and
// data memory ports.
//   master : sequencer side (drives request valid / store flag)
//   slave  : memory side (drives ready, response valid, fetch data)
// Signals:
//   ifu_req_valid  fetch request           ifu_req_ready   fetch request accepted
//   ifu_resp_valid fetch data valid        ifu_rdata       fetched instruction word
//   lsu_req_valid  data memory request     lsu_req_we      request is a store
//   lsu_req_ready  data request accepted   lsu_resp_valid  load data / store ack
interface ysyx_exec_ctrl_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_we;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;

    modport master (
        output ifu_req_valid, lsu_req_valid, lsu_req_we,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
               lsu_req_ready, lsu_resp_valid
    );

    modport slave (
        input  ifu_req_valid, lsu_req_valid, lsu_req_we,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
               lsu_req_ready, lsu_resp_valid
    );
endinterface

// File: rtl/ysyx_exec_ctrl.sv
// Multi-cycle sequencer for the single-issue core. Walks one instruction at a
// time through fetch, execute, optional memory access and write-back, and
// produces the cycle-exact PC / register-file write strobes.
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   bus            memory handshakes (master side of ysyx_exec_ctrl_if)
//   inst           latched instruction word feeding the decoder
//   dec_*          decoder control outputs for the held instruction
//   pc_wr_en       PC update strobe (write-back cycle)
//   rf_wr_en       register-file write strobe (write-back, if rd is written)
//   retire_cnt     instructions retired since reset (wraps)
//   halt           core stopped by ebreak or error, sticky
//   err            handshake timeout, sticky
// Parameter:
//   TIMEOUT        cycles allowed in one wait state before ERR (1..65535)
module ysyx_exec_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_exec_ctrl_if.master    bus,
    output logic [31:0]         inst,
    input  logic                dec_rf_wr_en,
    input  logic [2:0]          dec_dm_rd_sel,
    input  logic [1:0]          dec_dm_wr_sel,
    input  logic                dec_ebreak,
    output logic                pc_wr_en,
    output logic                rf_wr_en,
    output logic [31:0]         retire_cnt,
    output logic                halt,
    output logic                err
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_IF_REQ   = 4'd1;
    localparam logic [3:0] S_IF_WAIT  = 4'd2;
    localparam logic [3:0] S_EXEC     = 4'd3;
    localparam logic [3:0] S_MEM_REQ  = 4'd4;
    localparam logic [3:0] S_MEM_WAIT = 4'd5;
    localparam logic [3:0] S_WB       = 4'd6;
    localparam logic [3:0] S_HALT     = 4'd7;
    localparam logic [3:0] S_ERR      = 4'd8;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;
    logic        in_wait;
    logic        hs;

    assign wait_inc = wait_cnt + 16'd1;

    always_comb begin
        state_nxt = state;
        in_wait   = 1'b0;
        hs        = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_IF_REQ;
            S_IF_REQ: begin
                in_wait = 1'b1;
                hs      = bus.ifu_req_ready;
                if (hs) state_nxt = S_IF_WAIT;
            end
            S_IF_WAIT: begin
                in_wait = 1'b1;
                hs      = bus.ifu_resp_valid;
                if (hs) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (dec_ebreak)
                    state_nxt = S_HALT;
                else if (dec_dm_rd_sel != 3'd0 || dec_dm_wr_sel != 2'd0)
                    state_nxt = S_MEM_REQ;
                else
                    state_nxt = S_WB;
            end
            S_MEM_REQ: begin
                in_wait = 1'b1;
                hs      = bus.lsu_req_ready;
                if (hs) state_nxt = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                in_wait = 1'b1;
                hs      = bus.lsu_resp_valid;
                if (hs) state_nxt = S_WB;
            end
            S_WB:   state_nxt = S_IF_REQ;
            S_HALT: state_nxt = S_HALT;
            S_ERR:  state_nxt = S_ERR;
            // An unreachable encoding is treated as a fault rather than
            // silently restarting execution.
            default: state_nxt = S_ERR;
        endcase
        // The cycle that would make the counter reach TIMEOUT is the last
        // one allowed; a handshake in that same cycle still wins.
        if (in_wait && !hs && wait_inc == TIMEOUT_W)
            state_nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= 16'd0;
            inst       <= 32'd0;
            retire_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= 16'd0;
            else if (in_wait)
                wait_cnt <= wait_inc;
            // inst is only touched by the accepted fetch response, so the
            // decoder outputs stay stable for EXEC, MEM_* and WB.
            if (state == S_IF_WAIT && bus.ifu_resp_valid)
                inst <= bus.ifu_rdata;
            if (state == S_WB)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign bus.ifu_req_valid = (state == S_IF_REQ);
    assign bus.lsu_req_valid = (state == S_MEM_REQ);
    assign bus.lsu_req_we    = (state == S_MEM_REQ) && (dec_dm_wr_sel != 2'd0);
    assign pc_wr_en          = (state == S_WB);
    assign rf_wr_en          = (state == S_WB) && dec_rf_wr_en;
    assign halt              = (state == S_HALT) || (state == S_ERR);
    assign err               = (state == S_ERR);

endmodule

// File: tb/tb_ysyx_exec_ctrl.sv
// Self-checking bench for ysyx_exec_ctrl. Each scenario is planned as a list
// of instructions with per-handshake delays; the plan expands into per-cycle
// memory stimulus and the per-cycle outputs the sequencer must show. Inputs
// that the sequencer must ignore are randomized.
module tb_ysyx_exec_ctrl;
    localparam int TO = 4;

    typedef struct packed {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        lr;
        logic        lv;
    } stim_t;

    typedef struct packed {
        logic        ifv;
        logic        lv;
        logic        lwe;
        logic        pc;
        logic        rf;
        logic        halt;
        logic        err;
        logic [31:0] inst;
        logic [31:0] rcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst;
    logic        dec_rf_wr_en;
    logic [2:0]  dec_dm_rd_sel;
    logic [1:0]  dec_dm_wr_sel;
    logic        dec_ebreak;
    logic        pc_wr_en;
    logic        rf_wr_en;
    logic [31:0] retire_cnt;
    logic        halt;
    logic        err;

    ysyx_exec_ctrl_if bus ();

    ysyx_exec_ctrl #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.master),
        .inst          (inst),
        .dec_rf_wr_en  (dec_rf_wr_en),
        .dec_dm_rd_sel (dec_dm_rd_sel),
        .dec_dm_wr_sel (dec_dm_wr_sel),
        .dec_ebreak    (dec_ebreak),
        .pc_wr_en      (pc_wr_en),
        .rf_wr_en      (rf_wr_en),
        .retire_cnt    (retire_cnt),
        .halt          (halt),
        .err           (err)
    );

    // Bench decoder: instruction fields chosen by the plan.
    assign dec_dm_rd_sel = inst[2:0];
    assign dec_dm_wr_sel = inst[4:3];
    assign dec_rf_wr_en  = inst[5];
    assign dec_ebreak    = inst[6];

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    stim_t sq[$];
    exp_t  eq[$];
    logic [31:0] m_inst;
    logic [31:0] m_rcnt;
    bit          m_store;

    int pc_hits[$];
    int n_lv, n_lwe, n_rf, n_ifv, first_err;

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rr = 1'($urandom);
        s.rv = 1'($urandom);
        s.rd = $urandom;
        s.lr = 1'($urandom);
        s.lv = 1'($urandom);
        return s;
    endfunction

    function automatic exp_t base();
        exp_t e;
        e = '0;
        e.inst = m_inst;
        e.rcnt = m_rcnt;
        return e;
    endfunction

    task automatic push(input stim_t s, input exp_t e);
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        bus.ifu_req_ready  = s.rr;
        bus.ifu_resp_valid = s.rv;
        bus.ifu_rdata      = s.rd;
        bus.lsu_req_ready  = s.lr;
        bus.lsu_resp_valid = s.lv;
    endtask

    // kind: 0 fetch request, 1 fetch response, 2 data request, 3 data response.
    // d = idle cycles before the handshake; d >= TO means it never arrives.
    task automatic seg(input int kind, input int d, input logic [31:0] word, output bit dead);
        int n;
        stim_t s;
        exp_t e;
        bit hs;
        dead = (d >= TO);
        n = dead ? TO : d + 1;
        for (int j = 0; j < n; j++) begin
            s = rnd_stim();
            e = base();
            hs = (j == d);
            case (kind)
                0: begin s.rr = hs; e.ifv = 1'b1; end
                1: begin s.rv = hs; if (hs) s.rd = word; end
                2: begin s.lr = hs; e.lv = 1'b1; e.lwe = m_store; end
                default: s.lv = hs;
            endcase
            push(s, e);
            if (kind == 1 && hs) m_inst = word;
        end
    endtask

    task automatic terminal(input bit is_err);
        exp_t e;
        for (int j = 0; j < 6; j++) begin
            e = base();
            e.halt = 1'b1;
            e.err = is_err;
            push(rnd_stim(), e);
        end
    endtask

    // cls: 0 ALU, 1 load, 2 store, 3 ebreak
    task automatic inst_op(input int cls, input bit rf, input int a, input int b,
                           input int c, input int d, output bit stop);
        logic [31:0] w;
        bit dead;
        exp_t e;
        w = $urandom;
        case (cls)
            0: begin w[4:0] = 5'd0; w[6] = 1'b0; end
            1: begin w[2:0] = 3'($urandom_range(1, 7)); w[4:3] = 2'd0; w[6] = 1'b0; end
            2: begin w[2:0] = 3'd0; w[4:3] = 2'($urandom_range(1, 3)); w[6] = 1'b0; end
            default: w[6] = 1'b1;
        endcase
        w[5] = rf;
        stop = 1'b1;
        seg(0, a, w, dead);
        if (dead) begin terminal(1'b1); return; end
        seg(1, b, w, dead);
        if (dead) begin terminal(1'b1); return; end
        m_store = (w[4:3] != 2'd0);
        push(rnd_stim(), base());
        if (cls == 3) begin terminal(1'b0); return; end
        if (cls == 1 || cls == 2) begin
            seg(2, c, w, dead);
            if (dead) begin terminal(1'b1); return; end
            seg(3, d, w, dead);
            if (dead) begin terminal(1'b1); return; end
        end
        e = base();
        e.pc = 1'b1;
        e.rf = rf;
        push(rnd_stim(), e);
        m_rcnt = m_rcnt + 32'd1;
        stop = 1'b0;
    endtask

    task automatic check(input int i);
        exp_t w;
        w = eq[i];
        tests++;
        if (bus.ifu_req_valid !== w.ifv || bus.lsu_req_valid !== w.lv ||
            bus.lsu_req_we !== w.lwe || pc_wr_en !== w.pc || rf_wr_en !== w.rf ||
            halt !== w.halt || err !== w.err || inst !== w.inst || retire_cnt !== w.rcnt) begin
            fails++;
            $display("FAIL cycle%0d: got ifv=%b lv=%b we=%b pc=%b rf=%b halt=%b err=%b inst=%h rcnt=%0d; want ifv=%b lv=%b we=%b pc=%b rf=%b halt=%b err=%b inst=%h rcnt=%0d",
                     i, bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_req_we, pc_wr_en, rf_wr_en,
                     halt, err, inst, retire_cnt, w.ifv, w.lv, w.lwe, w.pc, w.rf, w.halt, w.err,
                     w.inst, w.rcnt);
        end
        if (pc_wr_en) pc_hits.push_back(i);
        if (bus.lsu_req_valid) n_lv++;
        if (bus.lsu_req_we) n_lwe++;
        if (rf_wr_en) n_rf++;
        if (bus.ifu_req_valid) n_ifv++;
        if (err && first_err < 0) first_err = i;
    endtask

    task automatic run();
        for (int i = 0; i < eq.size(); i++) begin
            @(negedge clk);
            check(i);
            drive(sq[i]);
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(i);
            drive(sq[i]);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        logic [38:0] v;
        v = {bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_req_we, pc_wr_en, rf_wr_en,
             halt, err, inst | retire_cnt};
        tests++;
        if (v !== 39'd0) begin
            fails++;
            $display("FAIL %s: got outputs=%h inst=%h rcnt=%0d want all zero", name, v, inst, retire_cnt);
        end
    endtask

    task automatic start_scn();
        sq.delete();
        eq.delete();
        pc_hits.delete();
        m_inst = 32'd0;
        m_rcnt = 32'd0;
        m_store = 1'b0;
        n_lv = 0; n_lwe = 0; n_rf = 0; n_ifv = 0; first_err = -1;
    endtask

    // Reset, then release on a falling edge; the cycle up to the next rising
    // edge is IDLE, and plan cycle 0 is the first IF_REQ cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(rnd_stim());
        #1 check_zero("reset_async");
        @(negedge clk);
        drive(rnd_stim());
        @(negedge clk);
        check_zero("reset_hold");
        rst_n = 1'b1;
        check_zero("idle");
        drive(rnd_stim());
    endtask

    initial begin
        bit stop;
        int r, cls, a, b, c, d, which;
        drive('0);

        // Three ALU instructions, zero-wait memories.
        start_scn();
        for (int k = 0; k < 3; k++) inst_op(0, 1'b1, 0, 0, 0, 0, stop);
        do_reset();
        run();
        lit("alu_pc0", pc_hits.size() > 0 ? pc_hits[0] : -1, 3);
        lit("alu_pc1", pc_hits.size() > 1 ? pc_hits[1] : -1, 7);
        lit("alu_pc2", pc_hits.size() > 2 ? pc_hits[2] : -1, 11);
        lit("alu_rf_pulses", n_rf, 3);
        @(negedge clk);
        lit("alu_retire", retire_cnt, 3);

        // Load, request accepted after 3 idle cycles.
        start_scn();
        inst_op(1, 1'b1, 0, 0, 3, 0, stop);
        do_reset();
        run();
        lit("load_req_cycles", n_lv, 4);
        lit("load_rf_pulses", n_rf, 1);
        lit("load_we", n_lwe, 0);

        // Store without register write.
        start_scn();
        inst_op(2, 1'b0, 0, 0, 0, 0, stop);
        do_reset();
        run();
        lit("store_we", n_lwe, 1);
        lit("store_pc", pc_hits.size(), 1);
        lit("store_rf", n_rf, 0);

        // ALU then ebreak.
        start_scn();
        inst_op(0, 1'b1, 0, 0, 0, 0, stop);
        inst_op(3, 1'b1, 0, 0, 0, 0, stop);
        do_reset();
        run();
        lit("ebreak_retire", retire_cnt, 1);
        lit("ebreak_halt", halt, 1);
        lit("ebreak_fetches", n_ifv, 2);

        // Fetch response never arrives.
        start_scn();
        inst_op(0, 1'b1, 0, TO, 0, 0, stop);
        do_reset();
        run();
        lit("timeout_first_err", first_err, 5);
        lit("timeout_halt", halt, 1);

        // Fetch response on the last allowed cycle.
        start_scn();
        inst_op(0, 1'b1, 0, TO - 1, 0, 0, stop);
        do_reset();
        run();
        lit("late_resp_pc", pc_hits.size() > 0 ? pc_hits[0] : -1, 6);
        lit("late_resp_err", first_err, -1);

        // Reset pulsed while waiting for a load response.
        start_scn();
        inst_op(0, 1'b1, 0, 0, 0, 0, stop);
        inst_op(1, 1'b1, 0, 0, 0, 3, stop);
        do_reset();
        run_n(10);
        lit("pre_reset_retire", retire_cnt, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        start_scn();
        inst_op(0, 1'b1, 0, 0, 0, 0, stop);
        inst_op(2, 1'b1, 1, 2, 1, 2, stop);
        do_reset();
        run();

        // Randomized instruction streams.
        for (int sidx = 0; sidx < 12; sidx++) begin
            start_scn();
            for (int k = 0; k < 14; k++) begin
                r = $urandom_range(0, 19);
                a = $urandom_range(0, TO - 1);
                b = $urandom_range(0, TO - 1);
                c = $urandom_range(0, TO - 1);
                d = $urandom_range(0, TO - 1);
                if (r < 8) cls = 0;
                else if (r < 13) cls = 1;
                else if (r < 18) cls = 2;
                else if (r == 18) cls = 3;
                else begin
                    cls = 1;
                    which = $urandom_range(0, 3);
                    case (which)
                        0: a = TO + $urandom_range(0, 1);
                        1: b = TO + $urandom_range(0, 1);
                        2: c = TO + $urandom_range(0, 1);
                        default: d = TO + $urandom_range(0, 1);
                    endcase
                end
                inst_op(cls, 1'($urandom), a, b, c, d, stop);
                if (stop) break;
            end
            do_reset();
            run();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/ysyx_exec_ctrl.md
# ysyx_exec_ctrl

Multi-cycle sequencer for the single-issue core. It schedules the instruction fetch port, the decode/execute datapath and the data-memory port, one instruction at a time. It holds the fetched instruction for the decoder, consumes the decoder's control outputs, and produces the cycle-exact write strobes for the PC, register file and memory. It also counts retired instructions, stops on ebreak, and traps on stalled memory handshakes.

## Interface
- TIMEOUT, 255: maximum cycles spent in one wait state before error; legal range 1..65535.
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  out  1  fetch request to instruction memory.
- ifu_req_ready  in  1  instruction memory accepts request.
- ifu_resp_valid  in  1  fetch data valid.
- ifu_rdata  in  32  fetched instruction word.
- inst  out  32  latched instruction, drives decoder.
- dec_rf_wr_en  in  1  decoder: instruction writes rd.
- dec_dm_rd_sel  in  3  decoder load type, 0 = not a load.
- dec_dm_wr_sel  in  2  decoder store type, 0 = not a store.
- dec_ebreak  in  1  decoder: ebreak.
- lsu_req_valid  out  1  data memory request.
- lsu_req_we  out  1  request is a store.
- lsu_req_ready  in  1  data memory accepts request.
- lsu_resp_valid  in  1  load data / store ack valid.
- pc_wr_en  out  1  PC register update strobe.
- rf_wr_en  out  1  register file write strobe.
- retire_cnt  out  32  instructions retired since reset.
- halt  out  1  core stopped (ebreak or error), sticky.
- err  out  1  handshake timeout, sticky.

## Operation
- States: IDLE, IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
- IDLE: entered on reset; unconditional → IF_REQ next cycle.
- IF_REQ: ifu_req_valid=1; on ifu_req_ready → IF_WAIT. Valid stays high until accepted.
- IF_WAIT: on ifu_resp_valid, inst ← ifu_rdata → EXEC. A response in the IF_REQ accept cycle is ignored.
- EXEC: exactly one cycle; decoder inputs are sampled here. Priority: dec_ebreak → HALT; else dm_rd_sel≠0 or dm_wr_sel≠0 → MEM_REQ; else → WB.
- MEM_REQ: lsu_req_valid=1, lsu_req_we=(dec_dm_wr_sel≠0); on lsu_req_ready → MEM_WAIT.
- MEM_WAIT: on lsu_resp_valid → WB.
- WB: single cycle. pc_wr_en=1, rf_wr_en=dec_rf_wr_en, retire_cnt+1 (wraps 0xFFFFFFFF→0). → IF_REQ.
- HALT: halt=1; terminal until reset. The ebreak does not retire: no pc_wr_en, no retire_cnt increment.
- ERR: err=1, halt=1; terminal until reset.
- Timeout: a 16-bit wait counter clears on every state change. It increments each cycle spent in IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT. When the counter equals TIMEOUT while still waiting → ERR. A handshake arriving in the same cycle as the timeout takes priority (normal transition).
- All strobes are decoded from the state register only (Moore). Exceptions: rf_wr_en and lsu_req_we additionally AND decoder inputs, which are stable because inst is held.
- inst changes only on the IF_WAIT response cycle.

## Timing
- Reset (rst_n=0, async): state=IDLE, inst=0, retire_cnt=0, wait counter=0. All outputs 0: ifu_req_valid, lsu_req_valid, lsu_req_we, pc_wr_en, rf_wr_en, halt, err.
- With zero-wait memories (ready and resp the cycle after entry), an ALU instruction takes 4 cycles: IF_REQ, IF_WAIT, EXEC, WB.
- Loads and stores take 6 cycles under the same conditions.
- First ifu_req_valid is asserted the 2nd cycle after rst_n deasserts.
- Reset asserted mid-transaction aborts immediately. Any outstanding memory response after reset release is ignored unless the FSM is in the matching wait state.
- The ready/resp inputs are ignored in HALT and ERR.

## Test plan
- ALU stream: zero-wait memories, 3 addi (dec_rf_wr_en=1) → rf_wr_en/pc_wr_en pulse at cycles 4, 8, 12 after IDLE exit; retire_cnt=3.
- Load with lsu_req_ready delayed 3 cycles → lsu_req_valid held 4 cycles, one rf_wr_en pulse in WB, lsu_req_we=0.
- Store (dm_wr_sel=3, dec_rf_wr_en=0) → lsu_req_we=1, WB gives pc_wr_en=1, rf_wr_en=0.
- ebreak in EXEC → halt=1 next cycle, retire_cnt unchanged, no further ifu_req_valid.
- TIMEOUT=4, ifu_resp_valid never asserted → err=1 and halt=1 after 4 IF_WAIT cycles. Same setup with resp on the 4th cycle → no error, EXEC reached.
- rst_n pulsed low during MEM_WAIT → all outputs 0 asynchronously, retire_cnt=0, fetch restarts.
